// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, vote-point
// helpers and the parity check used when a frame completes.
package uart_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    function automatic int unsigned vote_first(input int unsigned rate);
        return rate / 2 - 1;
    endfunction

    function automatic int unsigned vote_mid(input int unsigned rate);
        return rate / 2;
    endfunction

    function automatic int unsigned vote_last(input int unsigned rate);
        return rate / 2 + 1;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // data_xor is the XOR of all payload bits.
    function automatic logic parity_mismatch(input logic data_xor,
                                             input logic parity_bit,
                                             input logic odd);
        return (data_xor ^ parity_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Word delivery interface of the UART receiver: data, error flags and a
// valid/ready handshake towards the consumer.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_parity_err,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_parity_err,
        input  rx_overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus the tick-qualified previous
// sample used to find start-bit falling edges.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic rx,
    output logic rx_sync,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            if (sample_tick) begin
                prev <= sync2;
            end
        end
    end

    assign rx_sync = sync2;
    // Requires a high sample first, so a stuck-low line never retriggers.
    assign fall    = prev & ~sync2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit majority voting, LSB-first
// assembly and valid/ready delivery of each word with error flags.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned SAMPLING_RATE = 16,
    parameter int unsigned PARITY_EN     = 0,
    parameter int unsigned PARITY_ODD    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sample_tick,
    input  logic           rx,
    output logic           rx_busy,
    uart_rx_ctrl_if.master bus
);

    localparam int unsigned TW = $clog2(SAMPLING_RATE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_V0   = TW'(vote_first(SAMPLING_RATE));
    localparam logic [TW-1:0] T_V1   = TW'(vote_mid(SAMPLING_RATE));
    localparam logic [TW-1:0] T_V2   = TW'(vote_last(SAMPLING_RATE));
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLING_RATE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          HAS_PARITY = (PARITY_EN != 0);
    localparam logic          ODD_SENSE  = (PARITY_ODD != 0);

    logic                 rx_s;
    logic                 fall;
    state_t               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 v0;
    logic                 v1;
    logic                 parity_bit;
    logic                 done;
    logic                 done_ferr;
    logic                 done_perr;

    logic at_v0;
    logic at_v1;
    logic at_v2;
    logic at_last;
    logic vote;

    uart_rx_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_sync     (rx_s),
        .fall        (fall)
    );

    assign at_v0   = sample_tick && (tick_cnt == T_V0);
    assign at_v1   = sample_tick && (tick_cnt == T_V1);
    assign at_v2   = sample_tick && (tick_cnt == T_V2);
    assign at_last = sample_tick && (tick_cnt == T_LAST);
    assign vote    = majority3(v0, v1, rx_s);
    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            parity_bit <= 1'b0;
            done       <= 1'b0;
            done_ferr  <= 1'b0;
            done_perr  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sample_tick) begin
                if (at_v0) begin
                    v0 <= rx_s;
                end
                if (at_v1) begin
                    v1 <= rx_s;
                end
                if (state != ST_IDLE) begin
                    tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        // The edge tick itself is tick 0 of the start bit.
                        if (fall) begin
                            state    <= ST_START;
                            tick_cnt <= TW'(1);
                        end
                    end
                    ST_START: begin
                        if (at_v2 && vote) begin
                            state    <= ST_IDLE;
                            tick_cnt <= '0;
                        end else if (at_last) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (at_v2) begin
                            shreg <= {vote, shreg[DATA_BITS-1:1]};
                        end
                        if (at_last) begin
                            if (bit_cnt == B_LAST) begin
                                bit_cnt <= '0;
                                state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (at_v2) begin
                            parity_bit <= vote;
                        end
                        if (at_last) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Leave at mid-stop to gain half a bit of resync margin.
                        if (at_v2) begin
                            state     <= ST_IDLE;
                            tick_cnt  <= '0;
                            done      <= 1'b1;
                            done_ferr <= ~vote;
                            done_perr <= HAS_PARITY &&
                                         parity_mismatch(^shreg, parity_bit, ODD_SENSE);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else begin
            bus.rx_overrun <= 1'b0;
            if (done) begin
                // An unaccepted word is kept; the new one is dropped.
                if (bus.rx_valid && !bus.rx_ready) begin
                    bus.rx_overrun <= 1'b1;
                end else begin
                    bus.rx_data       <= shreg;
                    bus.rx_frame_err  <= done_ferr;
                    bus.rx_parity_err <= done_perr;
                    bus.rx_valid      <= 1'b1;
                end
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_ctrl;

    localparam int unsigned BIT_CLKS = 64;
    localparam logic        B_ODD    = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } word_t;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic sample_tick = 1'b0;
    logic rx_a        = 1'b1;
    logic rx_b        = 1'b1;
    logic busy_a;
    logic busy_b;
    logic ready_rand  = 1'b0;
    logic ready_force = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned acc_a = 0;
    int unsigned acc_b = 0;
    int unsigned ovr_a = 0;
    int unsigned ovr_b = 0;
    int unsigned a0, b0, o0, which;
    logic [7:0]  rd;
    logic        rp, rs;
    word_t       wa, wb;
    word_t       exp_a[$];
    word_t       exp_b[$];

    uart_rx_ctrl_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_ctrl_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_ctrl #(
        .DATA_BITS     (8),
        .SAMPLING_RATE (16),
        .PARITY_EN     (0),
        .PARITY_ODD    (0)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx_a),
        .rx_busy     (busy_a),
        .bus         (bus_a)
    );

    uart_rx_ctrl #(
        .DATA_BITS     (8),
        .SAMPLING_RATE (16),
        .PARITY_EN     (1),
        .PARITY_ODD    (0)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rx          (rx_b),
        .rx_busy     (busy_b),
        .bus         (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
        end
    end

    initial begin
        bus_a.rx_ready = 1'b1;
        bus_b.rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) begin
                bus_a.rx_ready = ($urandom_range(0, 3) == 0);
                bus_b.rx_ready = ($urandom_range(0, 3) == 0);
            end else begin
                bus_a.rx_ready = ready_force;
                bus_b.rx_ready = ready_force;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what a correct receiver reports for the bits put on the line.
    function automatic word_t model(input logic [7:0] data, input logic pbit,
                                    input logic stop, input logic par_en);
        word_t w;
        int unsigned ones;
        ones   = $countones(data) + int'(pbit);
        w.data = data;
        w.ferr = (stop == 1'b0);
        w.perr = par_en && ((ones % 2) != int'(B_ODD));
        return w;
    endfunction

    task automatic expect_word(input int unsigned dut, input logic [7:0] data,
                               input logic pbit, input logic stop);
        if (dut == 0) exp_a.push_back(model(data, pbit, stop, 1'b0));
        else          exp_b.push_back(model(data, pbit, stop, 1'b1));
    endtask

    task automatic hold_line(input int unsigned dut, input logic v, input int unsigned clks);
        if (dut == 0) rx_a = v;
        else          rx_b = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int unsigned dut, input logic [7:0] data,
                              input logic pbit, input logic stop);
        hold_line(dut, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_line(dut, data[i], BIT_CLKS);
        if (dut == 1) hold_line(dut, pbit, BIT_CLKS);
        hold_line(dut, stop, BIT_CLKS);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_a.rx_valid && bus_a.rx_ready) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_word", 32'(bus_a.rx_valid), 32'd0);
            end else begin
                wa = exp_a.pop_front();
                check("a_data", 32'(bus_a.rx_data), 32'(wa.data));
                check("a_frame_err", 32'(bus_a.rx_frame_err), 32'(wa.ferr));
                check("a_parity_err", 32'(bus_a.rx_parity_err), 32'(wa.perr));
                acc_a++;
            end
        end
        if (rst_n && bus_b.rx_valid && bus_b.rx_ready) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_word", 32'(bus_b.rx_valid), 32'd0);
            end else begin
                wb = exp_b.pop_front();
                check("b_data", 32'(bus_b.rx_data), 32'(wb.data));
                check("b_frame_err", 32'(bus_b.rx_frame_err), 32'(wb.ferr));
                check("b_parity_err", 32'(bus_b.rx_parity_err), 32'(wb.perr));
                acc_b++;
            end
        end
        if (rst_n && bus_a.rx_overrun) ovr_a++;
        if (rst_n && bus_b.rx_overrun) ovr_b++;
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_a_data", 32'(bus_a.rx_data), 32'd0);
        check("rst_a_ferr", 32'(bus_a.rx_frame_err), 32'd0);
        check("rst_a_perr", 32'(bus_a.rx_parity_err), 32'd0);
        check("rst_a_busy", 32'(busy_a), 32'd0);
        check("rst_b_valid", 32'(bus_b.rx_valid), 32'd0);
        check("rst_b_overrun", 32'(bus_b.rx_overrun), 32'd0);
        @(posedge clk);
        #1;
        hold_line(0, 1'b1, 2 * BIT_CLKS);

        // Plain 8N1 frame
        a0 = acc_a;
        expect_word(0, 8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        check("a5_busy_after_stop", 32'(busy_a), 32'd0);
        check("a5_words", acc_a - a0, 32'd1);
        hold_line(0, 1'b1, BIT_CLKS);

        // Four-tick glitch is rejected at the start-bit vote
        a0 = acc_a;
        hold_line(0, 1'b0, 16);
        hold_line(0, 1'b1, 18);
        check("glitch_busy_mid", 32'(busy_a), 32'd1);
        hold_line(0, 1'b1, 12);
        check("glitch_busy_idle", 32'(busy_a), 32'd0);
        hold_line(0, 1'b1, 2 * BIT_CLKS);
        check("glitch_no_word", acc_a - a0, 32'd0);
        check("glitch_valid", 32'(bus_a.rx_valid), 32'd0);

        // Low stop bit followed by a long break
        a0 = acc_a;
        expect_word(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        hold_line(0, 1'b0, 20 * BIT_CLKS);
        check("break_words", acc_a - a0, 32'd1);
        check("break_busy", 32'(busy_a), 32'd0);
        hold_line(0, 1'b1, 2 * BIT_CLKS);
        check("break_release_words", acc_a - a0, 32'd1);
        expect_word(0, 8'h96, 1'b0, 1'b1);
        send_frame(0, 8'h96, 1'b0, 1'b1);
        hold_line(0, 1'b1, BIT_CLKS);
        check("break_recover_words", acc_a - a0, 32'd2);

        // Even parity: 0x07 has three ones
        b0 = acc_b;
        expect_word(1, 8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b0, 1'b1);
        hold_line(1, 1'b1, BIT_CLKS);
        expect_word(1, 8'h07, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        hold_line(1, 1'b1, BIT_CLKS);
        check("parity_words", acc_b - b0, 32'd2);

        // Back-to-back frames while the consumer stalls
        ready_force = 1'b0;
        hold_line(0, 1'b1, 4);
        a0 = acc_a;
        o0 = ovr_a;
        expect_word(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        hold_line(0, 1'b1, BIT_CLKS);
        check("ovr_valid_held", 32'(bus_a.rx_valid), 32'd1);
        check("ovr_data_kept", 32'(bus_a.rx_data), 32'h11);
        check("ovr_pulses", ovr_a - o0, 32'd1);
        check("ovr_none_accepted", acc_a - a0, 32'd0);
        ready_force = 1'b1;
        hold_line(0, 1'b1, 8);
        check("ovr_accepted", acc_a - a0, 32'd1);
        check("ovr_valid_drop", 32'(bus_a.rx_valid), 32'd0);

        // Reset during data bit 4 abandons the frame
        a0 = acc_a;
        hold_line(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold_line(0, 1'b1, BIT_CLKS);
        hold_line(0, 1'b1, BIT_CLKS / 2);
        check("rst_mid_busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        hold_line(0, 1'b1, 3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_mid_data", 32'(bus_a.rx_data), 32'd0);
        @(posedge clk);
        #1;
        hold_line(0, 1'b1, 12 * BIT_CLKS);
        check("rst_mid_no_word", acc_a - a0, 32'd0);
        expect_word(0, 8'h5A, 1'b0, 1'b1);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        hold_line(0, 1'b1, BIT_CLKS);
        check("rst_mid_next_word", acc_a - a0, 32'd1);

        // Random frames on both instances with a random consumer
        ready_rand = 1'b1;
        for (int n = 0; n < 12; n++) begin
            which = n % 2;
            rd    = 8'($urandom);
            rp    = 1'($urandom_range(0, 1));
            rs    = ($urandom_range(0, 3) != 0);
            expect_word(which, rd, rp, rs);
            send_frame(which, rd, rp, rs);
            hold_line(which, 1'b1, $urandom_range(BIT_CLKS, 3 * BIT_CLKS));
        end
        ready_rand  = 1'b0;
        ready_force = 1'b1;
        for (int i = 0; i < 200 && (exp_a.size() != 0 || exp_b.size() != 0); i++) begin
            @(posedge clk);
        end
        #1;
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("a_overrun_total", ovr_a, 32'd1);
        check("b_overrun_total", ovr_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART IP. It consumes the oversampling strobe from the rx baud/sample generator and the raw serial line. It detects start bits, majority-votes each bit at mid-bit, and assembles LSB-first frames. Each completed word is presented with error flags on a valid/ready interface to the downstream consumer (FIFO or register block).

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
SAMPLING_RATE, 16, sample ticks per bit period (even, >= 8)
PARITY_EN, 0, 1 = one parity bit follows data
PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
sample_tick  input  1  one-clk-wide strobe at baud*SAMPLING_RATE, generated in the clk domain
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, LSB = first bit on line
rx_valid  output  1  rx_data and flags valid; held until accepted
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
rx_frame_err  output  1  stop bit sampled low; qualified by rx_valid
rx_parity_err  output  1  parity mismatch; qualified by rx_valid; 0 when PARITY_EN=0
rx_overrun  output  1  one-clk pulse: frame completed while previous word still unaccepted
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at posedge clk): state=IDLE, all counters 0, rx_data=0, rx_valid=0, both error flags 0, rx_overrun=0, synchronizer flops=1. Reset mid-frame abandons the frame; no word is delivered.
- rx passes through a 2-flop synchronizer (reset value 1), then a sampled-previous register updated on sample_tick.
- Counters advance only on sample_tick:
  - tick_cnt: $clog2(SAMPLING_RATE) bits, runs 0..SAMPLING_RATE-1 and wraps.
  - bit_cnt: $clog2(DATA_BITS+1) bits.
- Mid-bit majority vote: samples are taken at tick_cnt = S/2-1, S/2 and S/2+1 (S = SAMPLING_RATE). The 2-of-3 value is decided at tick S/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick where prev=1 and sync rx=0 (falling edge), go to START with tick_cnt=1; that tick counts as tick 0.
  - START: at the vote, result 1 -> IDLE (false start, glitch rejected), result 0 -> continue. At tick S-1, go to DATA with tick_cnt=0 and bit_cnt=0.
  - DATA: at each vote, shift the bit into the shift register LSB-first. At tick S-1, bit_cnt++. When bit_cnt reaches DATA_BITS-1 and tick S-1 occurs, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: vote into parity_bit; at tick S-1 go to STOP. Error condition: ^data ^ parity_bit != PARITY_ODD.
  - STOP: at the vote (mid-stop), latch the word and errors and go to IDLE immediately. This gives half a bit of resync margin for the next start edge. frame_err is set when the vote result is 0.
- Output handshake:
  - The word is latched in the clk cycle after the mid-stop vote tick; rx_valid rises on that same edge.
  - rx_valid stays high until a cycle with rx_ready=1, then clears on the next edge.
  - rx_data and the flags are stable while rx_valid=1.
- Overrun: if a frame completes while rx_valid=1 and rx_ready=0, the new word is dropped, the old word is kept, and rx_overrun pulses for one clk. If rx_ready=1 in that same cycle, the old word is accepted, the new word is loaded, rx_valid stays 1, and there is no overrun.
- Break or stuck-low line: reported as a frame with frame_err=1. No new start is detected until the line returns high, because the falling edge requires prev=1.
- sample_tick held low stalls all counters; the FSM does not time out.
- Latency from the line: 2 clk of synchronizer, plus the tick-grid alignment of up to one tick period.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits.
  - vote-point localparams derived from SAMPLING_RATE.
  - parity helper function.
- One sub-module, uart_rx_sync: 2-flop synchronizer plus the tick-qualified prev register and falling-edge output. Same clk and rst_n.
- Tick source: the existing rx divider, adapted to emit a one-clk strobe.

Test Plan:
- 8N1 frame 0xA5, SAMPLING_RATE=16, sample_tick every 4 clk, rx_ready=1 -> single rx_valid with rx_data=0xA5, both error flags 0, rx_busy low after mid-stop.
- rx low for 4 ticks only (glitch), then high -> FSM returns to IDLE at tick 9, no rx_valid.
- Frame 0x3C with the stop bit driven low -> rx_data=0x3C, rx_frame_err=1. The line is then held low for 20 bit times -> no further frames until rx rises and a new falling edge occurs.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 with parity bit 0 -> rx_parity_err=1. Repeated with parity bit 1 -> rx_parity_err=0.
- Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11 and rx_overrun pulses once. rx_ready is then raised -> 0x11 is accepted and rx_valid drops.
- rst_n asserted low during data bit 4 of 0xFF -> no rx_valid. A following 0x5A frame is received correctly.
